// File: rtl/trigger_buffer_pkg.sv
// Shared FSM state type and event-word layout for the trigger capture/readout path.
// Bit offsets are relative to TS_WIDTH: the tag byte sits directly above the timestamp.
package trigger_buffer_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    DRAIN   = 2'd1,
    RESUME  = 2'd2
  } state_t;

  localparam int TAG_BITS = 8;
  localparam int OVF_OFS  = 7;
  localparam int CH2_OFS  = 6;
  localparam int CH1_OFS  = 5;

  function automatic int evt_width(input int ts_width);
    return ts_width + TAG_BITS;
  endfunction

endpackage

// File: rtl/trigger_event_buffer_if.sv
// Readout bus between the event buffer (slave) and the ESP32 interface logic (master).
interface trigger_event_buffer_if #(
  parameter int TS_WIDTH = 32,
  parameter int DEPTH    = 16
);
  import trigger_buffer_pkg::*;

  localparam int EW = evt_width(TS_WIDTH);

  logic                   READ_START;
  logic                   READ_REQ;
  logic                   READ_DONE;
  logic                   READ_MODE;
  logic [EW-1:0]          DATA_OUT;
  logic                   DATA_VALID;
  logic [$clog2(DEPTH):0] FIFO_COUNT;
  logic                   OVERFLOW;
  logic [15:0]            DROP_COUNT;

  modport master (
    output READ_START, READ_REQ, READ_DONE,
    input  READ_MODE, DATA_OUT, DATA_VALID, FIFO_COUNT, OVERFLOW, DROP_COUNT
  );

  modport slave (
    input  READ_START, READ_REQ, READ_DONE,
    output READ_MODE, DATA_OUT, DATA_VALID, FIFO_COUNT, OVERFLOW, DROP_COUNT
  );

endinterface

// File: rtl/event_fifo.sv
// Single-clock event FIFO with registered read data and synchronous flush.
// Push into a full FIFO and pop from an empty one are silently ignored.
module event_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trigger_event_buffer.sv
// Timestamps trigger rising edges with channel-hit tags, buffers them, and drains them on request.
//   state   | meaning
//   ACQUIRE | captures enabled, READ_MODE low
//   DRAIN   | captures disabled, READ_REQ pops one word per cycle
//   RESUME  | post-readout dead-time, READ_MODE still high
module trigger_event_buffer
  import trigger_buffer_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32,
  parameter int HOLDOFF  = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TRIGGER_IN,
  input  logic SIGNAL1,
  input  logic SIGNAL2,
  input  logic CLEAR,
  trigger_event_buffer_if.slave rd
);
  localparam int EW = evt_width(TS_WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [CW-1:0] ONE_LEFT  = CW'(1);

  state_t        state;
  logic [TS_WIDTH-1:0] ts;
  logic          trig_d;
  logic          ch1_seen;
  logic          ch2_seen;
  logic          pend_ovf;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [HW-1:0] holdoff;
  logic          read_mode;
  logic          pop_d;
  logic          data_valid;
  logic [EW-1:0] data_out;
  logic [EW-1:0] evt_word;
  logic [EW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          rise;
  logic          capture;
  logic          push;
  logic          drop;
  logic          pop;

  assign rise    = TRIGGER_IN && !trig_d;
  assign capture = !CLEAR && (state == ACQUIRE) && rise && (holdoff == '0);
  assign push    = capture && !fifo_full;
  assign drop    = capture && fifo_full;
  assign pop     = !CLEAR && (state == DRAIN) && rd.READ_REQ && !fifo_empty;

  // Channel bits include hits arriving in the capture cycle itself.
  always_comb begin
    evt_word = '0;
    evt_word[TS_WIDTH-1:0]       = ts;
    evt_word[TS_WIDTH + CH1_OFS] = ch1_seen | SIGNAL1;
    evt_word[TS_WIDTH + CH2_OFS] = ch2_seen | SIGNAL2;
    evt_word[TS_WIDTH + OVF_OFS] = pend_ovf;
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (CLEAR),
    .push  (push),
    .pop   (pop),
    .wdata (evt_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ts         <= '0;
      trig_d     <= 1'b0;
      ch1_seen   <= 1'b0;
      ch2_seen   <= 1'b0;
      pend_ovf   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      pop_d      <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      ts         <= ts + 1'b1;
      trig_d     <= TRIGGER_IN;
      pop_d      <= pop;
      data_valid <= pop_d;
      if (pop_d) data_out <= fifo_rdata;
      if (CLEAR) begin
        ch1_seen   <= 1'b0;
        ch2_seen   <= 1'b0;
        pend_ovf   <= 1'b0;
        overflow   <= 1'b0;
        drop_count <= '0;
      end else begin
        if (capture) begin
          ch1_seen <= SIGNAL1;
          ch2_seen <= SIGNAL2;
        end else begin
          ch1_seen <= ch1_seen | SIGNAL1;
          ch2_seen <= ch2_seen | SIGNAL2;
        end
        if (push) pend_ovf <= 1'b0;
        if (drop) begin
          pend_ovf <= 1'b1;
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

  // Holdoff lives with the FSM because RESUME entry reloads it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ACQUIRE;
      read_mode <= 1'b0;
      holdoff   <= '0;
    end else if (CLEAR) begin
      state     <= ACQUIRE;
      read_mode <= 1'b0;
      holdoff   <= '0;
    end else begin
      if (holdoff != '0) holdoff <= holdoff - 1'b1;
      case (state)
        ACQUIRE: begin
          if (capture) holdoff <= HOLD_LOAD;
          if (rd.READ_START) begin
            state     <= DRAIN;
            read_mode <= 1'b1;
          end
        end
        DRAIN: begin
          if (rd.READ_DONE || fifo_empty || (pop && fifo_count == ONE_LEFT)) begin
            state   <= RESUME;
            holdoff <= HOLD_LOAD;
          end
        end
        RESUME: begin
          if (holdoff == '0) begin
            state     <= ACQUIRE;
            read_mode <= 1'b0;
          end
        end
        default: begin
          state     <= ACQUIRE;
          read_mode <= 1'b0;
        end
      endcase
    end
  end

  assign rd.READ_MODE  = read_mode;
  assign rd.DATA_OUT   = data_out;
  assign rd.DATA_VALID = data_valid;
  assign rd.FIFO_COUNT = fifo_count;
  assign rd.OVERFLOW   = overflow;
  assign rd.DROP_COUNT = drop_count;

endmodule

// File: tb/tb_trigger_event_buffer.sv
// Bench for trigger_event_buffer: queue-based event model checked every cycle, plus literal pins.
module tb_trigger_event_buffer;
  localparam int DEPTH    = 16;
  localparam int TS_WIDTH = 32;
  localparam int HOLDOFF  = 8;
  localparam int EW       = TS_WIDTH + 8;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic TRIGGER_IN = 1'b0;
  logic SIGNAL1 = 1'b0;
  logic SIGNAL2 = 1'b0;
  logic CLEAR = 1'b0;

  trigger_event_buffer_if #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)) bus ();

  trigger_event_buffer #(
    .DEPTH    (DEPTH),
    .TS_WIDTH (TS_WIDTH),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .TRIGGER_IN (TRIGGER_IN),
    .SIGNAL1    (SIGNAL1),
    .SIGNAL2    (SIGNAL2),
    .CLEAR      (CLEAR),
    .rd         (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: events in a queue, readout modelled as queue pops.
  typedef enum int {M_ACQ, M_DRAIN, M_RESUME} mstate_t;
  mstate_t m_state = M_ACQ;
  logic [EW-1:0] m_q[$];
  logic [TS_WIDTH-1:0] m_ts = '0;
  bit m_trig_prev = 0, m_ch1 = 0, m_ch2 = 0, m_pend = 0, m_ovf = 0;
  bit m_dvalid = 0, m_rmode = 0, m_out_pend = 0;
  int m_drops = 0, m_hold = 0;
  logic [EW-1:0] m_dout = '0, m_out_word = '0;

  task automatic model_reset();
    m_state = M_ACQ; m_q.delete(); m_ts = '0;
    m_trig_prev = 0; m_ch1 = 0; m_ch2 = 0; m_pend = 0; m_ovf = 0;
    m_dvalid = 0; m_rmode = 0; m_out_pend = 0; m_drops = 0; m_hold = 0;
    m_dout = '0; m_out_word = '0;
  endtask

  task automatic model_step();
    bit rise, s1, s2;
    int hold_nx;
    logic [EW-1:0] w;
    s1 = SIGNAL1; s2 = SIGNAL2;
    rise = TRIGGER_IN && !m_trig_prev;
    m_dvalid = m_out_pend;
    if (m_out_pend) m_dout = m_out_word;
    m_out_pend = 0;
    if (CLEAR) begin
      m_q.delete(); m_ovf = 0; m_drops = 0; m_pend = 0;
      m_ch1 = 0; m_ch2 = 0; m_hold = 0; m_state = M_ACQ;
    end else begin
      hold_nx = (m_hold > 0) ? m_hold - 1 : 0;
      if (m_state == M_ACQ && rise && m_hold == 0) begin
        w = '0;
        w[TS_WIDTH-1:0] = m_ts;
        w[EW-1] = m_pend;
        w[EW-2] = m_ch2 | s2;
        w[EW-3] = m_ch1 | s1;
        if (m_q.size() < DEPTH) begin
          m_q.push_back(w);
          m_pend = 0;
        end else begin
          m_ovf = 1; m_pend = 1;
          if (m_drops < 65535) m_drops++;
        end
        hold_nx = HOLDOFF;
        m_ch1 = s1; m_ch2 = s2;
      end else begin
        m_ch1 = m_ch1 | s1; m_ch2 = m_ch2 | s2;
      end
      case (m_state)
        M_ACQ: if (bus.READ_START) m_state = M_DRAIN;
        M_DRAIN: begin
          if (bus.READ_REQ && m_q.size() > 0) begin
            m_out_word = m_q.pop_front();
            m_out_pend = 1;
          end
          if (bus.READ_DONE || m_q.size() == 0) begin
            m_state = M_RESUME;
            hold_nx = HOLDOFF;
          end
        end
        default: if (m_hold == 0) m_state = M_ACQ;
      endcase
      m_hold = hold_nx;
    end
    m_ts = m_ts + 1;
    m_trig_prev = TRIGGER_IN;
    m_rmode = (m_state != M_ACQ);
  endtask

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) model_reset();
    else model_step();
  end

  logic [EW-1:0] got_word[$];
  int got_edge[$];

  always @(negedge CLK) begin
    check("read_mode", bus.READ_MODE, m_rmode);
    check("data_valid", bus.DATA_VALID, m_dvalid);
    check("data_out", bus.DATA_OUT, m_dout);
    check("fifo_count", bus.FIFO_COUNT, m_q.size());
    check("overflow", bus.OVERFLOW, m_ovf);
    check("drop_count", bus.DROP_COUNT, m_drops);
    if (bus.DATA_VALID === 1'b1) begin
      got_word.push_back(bus.DATA_OUT);
      got_edge.push_back(int'(m_ts) - 1);
    end
  end

  // Returns 2 time units after the edge preceding the one that samples counter value v.
  task automatic at_ts(input int v);
    int n = 0;
    while (m_ts != v) begin
      @(posedge CLK); #2;
      n++;
      if (n > 2000) begin
        n_checks++; n_err++;
        $display("FAIL at_ts timeout: counter %0d never reached %0d", m_ts, v);
        return;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mode"}, bus.READ_MODE, 0);
    check({tag, "_dvalid"}, bus.DATA_VALID, 0);
    check({tag, "_dout"}, bus.DATA_OUT, 0);
    check({tag, "_count"}, bus.FIFO_COUNT, 0);
    check({tag, "_ovf"}, bus.OVERFLOW, 0);
    check({tag, "_drops"}, bus.DROP_COUNT, 0);
  endtask

  initial begin
    bus.READ_START = 0; bus.READ_REQ = 0; bus.READ_DONE = 0;
    #12;
    check_zero_outputs("rst");
    #10 RESET = 1;

    // Hit flag then first capture at counter 10.
    at_ts(5);  SIGNAL1 = 1;
    at_ts(6);  SIGNAL1 = 0;
    at_ts(10); TRIGGER_IN = 1;
    at_ts(11); @(negedge CLK);
    check("t1_count", bus.FIFO_COUNT, 1);
    at_ts(14); TRIGGER_IN = 0;

    // Edge at 23 falls inside holdoff of the 20 capture.
    at_ts(20); TRIGGER_IN = 1;
    at_ts(21); TRIGGER_IN = 0;
    at_ts(23); TRIGGER_IN = 1;
    at_ts(24); TRIGGER_IN = 0;
    at_ts(26); @(negedge CLK);
    check("t2_count", bus.FIFO_COUNT, 2);
    check("t2_drops", bus.DROP_COUNT, 0);

    at_ts(30); TRIGGER_IN = 1; SIGNAL2 = 1;
    at_ts(31); TRIGGER_IN = 0; SIGNAL2 = 0;

    // Readout of three events, then RESUME with an ignored trigger.
    at_ts(40); bus.READ_START = 1;
    at_ts(41); bus.READ_START = 0;
    @(negedge CLK);
    check("rd_mode_on", bus.READ_MODE, 1);
    at_ts(42); bus.READ_REQ = 1;
    at_ts(45); bus.READ_REQ = 0;
    at_ts(48); TRIGGER_IN = 1;
    at_ts(51); TRIGGER_IN = 0;
    at_ts(53); @(negedge CLK);
    check("resume_mode_hi", bus.READ_MODE, 1);
    at_ts(54); @(negedge CLK);
    check("resume_mode_lo", bus.READ_MODE, 0);
    check("resume_no_cap", bus.FIFO_COUNT, 0);

    // Seventeen spaced triggers into a 16-deep FIFO.
    for (int k = 0; k < 17; k++) begin
      at_ts(60 + 10*k); TRIGGER_IN = 1;
      at_ts(61 + 10*k); TRIGGER_IN = 0;
    end
    at_ts(222); @(negedge CLK);
    check("ovf_count", bus.FIFO_COUNT, 16);
    check("ovf_flag", bus.OVERFLOW, 1);
    check("ovf_drops", bus.DROP_COUNT, 1);

    at_ts(230); bus.READ_START = 1;
    at_ts(231); bus.READ_START = 0;
    at_ts(232); bus.READ_REQ = 1;
    at_ts(233); bus.READ_REQ = 0;
    at_ts(234); bus.READ_DONE = 1;
    at_ts(235); bus.READ_DONE = 0;
    at_ts(250); TRIGGER_IN = 1;
    at_ts(251); TRIGGER_IN = 0;
    at_ts(252); @(negedge CLK);
    check("refill_count", bus.FIFO_COUNT, 16);

    // Drain all sixteen back to back.
    at_ts(260); bus.READ_START = 1;
    at_ts(261); bus.READ_START = 0;
    at_ts(262); bus.READ_REQ = 1;
    at_ts(278); bus.READ_REQ = 0;

    // Five events, with a stray READ_REQ in ACQUIRE, then CLEAR racing READ_START.
    for (int k = 0; k < 5; k++) begin
      at_ts(290 + 10*k); TRIGGER_IN = 1;
      at_ts(291 + 10*k); TRIGGER_IN = 0;
      if (k == 1) begin
        at_ts(305); bus.READ_REQ = 1;
        at_ts(306); bus.READ_REQ = 0;
      end
    end
    at_ts(333); @(negedge CLK);
    check("pre_clr_count", bus.FIFO_COUNT, 5);
    check("pre_clr_ovf", bus.OVERFLOW, 1);
    at_ts(335); CLEAR = 1; bus.READ_START = 1;
    at_ts(336); CLEAR = 0; bus.READ_START = 0;
    @(negedge CLK);
    check("clr_count", bus.FIFO_COUNT, 0);
    check("clr_ovf", bus.OVERFLOW, 0);
    check("clr_drops", bus.DROP_COUNT, 0);
    check("clr_mode", bus.READ_MODE, 0);

    // Capture and READ_START in the same cycle.
    at_ts(340); TRIGGER_IN = 1; bus.READ_START = 1;
    at_ts(341); TRIGGER_IN = 0; bus.READ_START = 0;
    @(negedge CLK);
    check("same_cyc_mode", bus.READ_MODE, 1);
    check("same_cyc_count", bus.FIFO_COUNT, 1);
    at_ts(342); bus.READ_REQ = 1;
    at_ts(343); bus.READ_REQ = 0;

    // Reset asserted mid-DRAIN acts without a clock edge.
    at_ts(360); TRIGGER_IN = 1;
    at_ts(361); TRIGGER_IN = 0;
    at_ts(365); bus.READ_START = 1;
    at_ts(366); bus.READ_START = 0;
    at_ts(368);
    check("pre_arst_mode", bus.READ_MODE, 1);
    check("pre_arst_count", bus.FIFO_COUNT, 1);
    check("pre_arst_dout", bus.DATA_OUT, 40'h00_00000154);
    RESET = 0;
    #1;
    check_zero_outputs("arst");

    // Hand-computed readout words and strobe timing.
    check("strobe_total", got_word.size(), 21);
    if (got_word.size() >= 21) begin
      check("rd0_word", got_word[0], 40'h20_0000000A);
      check("rd1_word", got_word[1], 40'h00_00000014);
      check("rd2_word", got_word[2], 40'h40_0000001E);
      check("rd0_edge", got_edge[0], 43);
      check("rd1_edge", got_edge[1], 44);
      check("rd2_edge", got_edge[2], 45);
      check("ts60_word", got_word[3], 40'h40_0000003C);
      check("ts70_word", got_word[4], 40'h00_00000046);
      check("ovf_word", got_word[19], 40'h80_000000FA);
      check("post_clr_word", got_word[20], 40'h00_00000154);
    end

    @(negedge CLK);
    #3 RESET = 1;
    repeat (5) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_event_buffer.md
# trigger_event_buffer

Capture and readout stage directly downstream of the two-channel edge trigger. Each rising edge of the trigger output is stamped with a free-running cycle counter and tagged with which detector channels fired since the last capture. The tagged event is pushed into an on-chip FIFO. A readout state machine drains that FIFO to the ESP32 interface logic and drives READ_MODE back to the trigger stage so triggers are inhibited while data is read.

## Interface
- DEPTH, 16: FIFO depth in events; power of two, at least 2.
- TS_WIDTH, 32: timestamp counter width.
- HOLDOFF, 8: cycles of capture dead-time after each capture and after readout ends; at least 1.
- CLK  in  1  single system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- TRIGGER_IN  in  1  trigger level from the edge trigger stage.
- SIGNAL1, SIGNAL2  in  1 each  raw channel hit pulses, already synchronous to CLK.
- READ_START  in  1  one-cycle request to enter readout.
- READ_REQ  in  1  one-cycle pop request, honoured only in DRAIN.
- READ_DONE  in  1  one-cycle request to end readout early.
- CLEAR  in  1  synchronous flush.
- READ_MODE  out  1  high in DRAIN and RESUME; feeds the trigger stage's read_mode input.
- DATA_OUT  out  TS_WIDTH+8  event word, registered.
- DATA_VALID  out  1  one-cycle strobe qualifying DATA_OUT.
- FIFO_COUNT  out  clog2(DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky; set on any dropped event.
- DROP_COUNT  out  16  saturating count of dropped events.

## Operation
- **Event word layout**:
  - bit TS_WIDTH+7: ovf.
  - bit TS_WIDTH+6: ch2_hit.
  - bit TS_WIDTH+5: ch1_hit.
  - bits TS_WIDTH+4 to TS_WIDTH: zero.
  - low TS_WIDTH bits: timestamp.
- **Timestamp counter**: increments every cycle and wraps modulo 2^TS_WIDTH. It is never cleared except by RESET; CLEAR does not touch it.
- **Hit flags**: ch1_seen and ch2_seen are sticky. Each is set on any cycle its SIGNAL is high. Both are cleared on a capture; when a SIGNAL is high in the capture cycle, its flag is re-set, not cleared.
- **Edge detect**: a rising edge is TRIGGER_IN high now and its registered previous value low.
- **Capture condition**: state is ACQUIRE, a rising edge is present and the holdoff counter is 0.
- **Capture contents**: the current timestamp, the flags OR'd with the current SIGNAL levels, and the ovf bit. ovf is set when any event was dropped since the last successful write.
- **Holdoff**: each capture loads the holdoff counter with HOLDOFF. Rising edges seen while it is non-zero are ignored and are not counted as drops.
- **FIFO full at capture**: no write. OVERFLOW is set, DROP_COUNT increments and saturates at 0xFFFF, and the pending-ovf flag is set. Holdoff is still loaded.
- **FSM states**:
  - ACQUIRE: captures enabled, READ_MODE=0. READ_START moves to DRAIN.
  - DRAIN: captures disabled. A READ_REQ while non-empty pops one word.
    - Exit to RESUME when a pop empties the FIFO.
    - Exit to RESUME on READ_DONE.
    - Exit to RESUME on the cycle after entry if the FIFO is empty.
  - RESUME: loads the holdoff counter with HOLDOFF on entry. Returns to ACQUIRE when the counter reaches 0. READ_MODE=1 in this state.
- **Ignored requests**: READ_REQ outside DRAIN, or while empty, is ignored and DATA_VALID stays 0. READ_START outside ACQUIRE is ignored.
- **CLEAR**:
  - Empties the FIFO and clears OVERFLOW, DROP_COUNT, the pending-ovf flag, the hit flags and the holdoff counter.
  - Forces the FSM to ACQUIRE.
  - Has priority over every other input in that cycle.

## Timing
- **Reset values**: READ_MODE=0, DATA_OUT=0, DATA_VALID=0, FIFO_COUNT=0, OVERFLOW=0, DROP_COUNT=0. FSM in ACQUIRE; timestamp, flags and holdoff counter all 0.
- **Capture latency**: for a rising edge at clock edge N, the stored timestamp is the counter value at N. FIFO_COUNT reflects the write after edge N.
- **Readout latency**: for READ_REQ at edge N, DATA_OUT and DATA_VALID update at edge N+1. DATA_VALID is high for exactly one cycle. DATA_OUT holds its value until the next pop.
- **READ_START and capture in the same cycle**: the capture is performed, then the FSM enters DRAIN, so the captured event is readable.
- **READ_REQ and READ_DONE in the same cycle**: the pop completes, then the FSM enters RESUME.
- **State/READ_MODE alignment**: READ_MODE is registered from state and goes high the cycle after READ_START.
- **Back-to-back pops**: one word per cycle.
- **Wrap**: the timestamp rolls from all-ones to 0 with no special handling. FIFO pointers wrap modulo DEPTH.

## Structure
- Package trigger_buffer_pkg holds:
  - the FSM state enum (ACQUIRE, DRAIN, RESUME);
  - event-word bit-position constants;
  - the event width expression TS_WIDTH+8.
- Sub-module event_fifo:
  - synchronous single-clock FIFO, parameterised by width and DEPTH;
  - ports: push, pop, full, empty, count;
  - registered read data.
- Top level holds the timestamp counter, edge detect, hit flags, holdoff counter, drop logic and FSM.

## Test plan
- After reset, SIGNAL1 pulse at counter value 5, then TRIGGER_IN rising at counter value 10 -> event word has ch1_hit=1, ch2_hit=0, ovf=0, timestamp=10; FIFO_COUNT=1.
- Rising edges at counter values 20 and 23 with HOLDOFF=8 -> only the 20 edge is captured; DROP_COUNT stays 0.
- 17 spaced triggers with DEPTH=16 -> FIFO_COUNT=16, OVERFLOW=1, DROP_COUNT=1; a pop followed by one more trigger yields a stored event with ovf=1.
- Readout of 3 events:
  - READ_START -> READ_MODE=1 next cycle;
  - 3 READ_REQ pulses -> three DATA_VALID strobes in FIFO order, each one cycle after its request;
  - FSM goes to RESUME, READ_MODE drops HOLDOFF+1 cycles later, and triggers during RESUME are not captured.
- CLEAR asserted with 5 events stored and OVERFLOW=1 -> FIFO_COUNT=0, OVERFLOW=0, DROP_COUNT=0, FSM in ACQUIRE, timestamp still counting.
- RESET deasserted then reasserted mid-DRAIN -> all outputs return to reset values immediately, without waiting for a clock edge.
